// File: rtl/serial_disp_pkg.sv
// ============================================================================
// serial_disp_pkg
// Shared constants and types for the serial display receiver slice.
//  LED_FRAME_BITS  : frame width of the LED shift chain
//  SEG_FRAME_BITS  : frame width of the 7-segment shift chain
//  DEF_SYNC_STAGES : default synchronizer depth per input line
//  rx_state_t      : receiver fill state (IDLE, SHIFTING, FULL)
// ============================================================================
package serial_disp_pkg;

   localparam int LED_FRAME_BITS  = 16;
   localparam int SEG_FRAME_BITS  = 64;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFTING = 2'd1,
      FULL     = 2'd2
   } rx_state_t;

endpackage

// File: rtl/ser_sync_edge.sv
// ============================================================================
// ser_sync_edge
// Brings one asynchronous serial line into the clk domain and detects its
// rising edge. The level and rise outputs are both registered after the
// synchronizer so that they stay cycle-aligned with each other and with every
// other instance of this block.
// Ports:
//  clk     : system clock, rising edge
//  rst     : synchronous active-high reset
//  din_i   : asynchronous input line
//  level_o : synchronized level, delayed SYNC_STAGES+1 cycles
//  rise_o  : one-cycle pulse aligned with the first high cycle of level_o
// ============================================================================
module ser_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   rise_q;

   // Synchronizer chain followed by the edge register. rise_q compares the
   // newest synchronized sample with the one edge_q is about to replace, so
   // rise_q and edge_q change on the same clock and describe the same sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
         edge_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
      end
   end

   assign level_o = edge_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/serial_disp_receiver.sv
// ============================================================================
// serial_disp_receiver
// Receive side of the serial LED/7-seg shift protocol. Oversamples the serial
// lines in the clk domain, shifts data in MSB first and presents a completed
// frame on par_out when the transmitter strobes ser_pen.
// Ports:
//  clk, rst    : system clock, synchronous active-high reset
//  ser_clk     : serial shift clock (async), data taken on its rising edge
//  ser_sout    : serial data, MSB first
//  ser_pen     : commit strobe, rising edge commits the frame
//  ser_clrn    : active-low clear of the shift register and bit counter
//  par_out     : last committed good frame
//  frame_valid : one-cycle pulse when par_out updates
//  frame_err   : last commit had the wrong bit count
//  bit_cnt     : bits shifted since last commit/clear, saturating
//  daisy_out   : MSB shifted out of the frame (only with DAISY_OUT_EN)
// Build option: define DAISY_OUT_EN to add the daisy_out port and its flop.
// ============================================================================
module serial_disp_receiver
   import serial_disp_pkg::*;
#(
   parameter int FRAME_BITS  = LED_FRAME_BITS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ser_clk,
   input  logic                  ser_sout,
   input  logic                  ser_pen,
   input  logic                  ser_clrn,
   output logic [FRAME_BITS-1:0] par_out,
   output logic                  frame_valid,
   output logic                  frame_err,
`ifdef DAISY_OUT_EN
   output logic [CNT_W-1:0]      bit_cnt,
   output logic                  daisy_out
`else
   output logic [CNT_W-1:0]      bit_cnt
`endif
);

   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

   logic clkRise, soutLevel, penRise, clrnLevel;
   logic unusedClkLevel, unusedSoutRise, unusedPenLevel, unusedClrnRise;

   logic [FRAME_BITS-1:0] sreg_q, sreg_d, par_q, par_d, shiftSreg;
   logic [CNT_W-1:0]      cnt_q, cnt_d, shiftCnt;
   logic                  err_q, err_d, valid_q, valid_d;
   rx_state_t             state_q, state_d, shiftState;

   // ser_sout goes through the same pipeline as ser_clk so the sampled data
   // bit lines up with the detected shift-clock edge.
   ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncClk (
      .clk(clk), .rst(rst), .din_i(ser_clk), .level_o(unusedClkLevel), .rise_o(clkRise)
   );
   ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncSout (
      .clk(clk), .rst(rst), .din_i(ser_sout), .level_o(soutLevel), .rise_o(unusedSoutRise)
   );
   ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncPen (
      .clk(clk), .rst(rst), .din_i(ser_pen), .level_o(unusedPenLevel), .rise_o(penRise)
   );
   ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncClrn (
      .clk(clk), .rst(rst), .din_i(ser_clrn), .level_o(clrnLevel), .rise_o(unusedClrnRise)
   );

   // State register for the shift/commit datapath and the fill-state FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q  <= '0;
         cnt_q   <= '0;
         par_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         state_q <= IDLE;
      end else begin
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

   // Next-state logic. The shift is worked out first (shiftSreg/shiftCnt/
   // shiftState) so a commit in the same cycle sees the frame including that
   // bit. Clear overrides everything and makes a simultaneous commit look
   // like an empty frame, which always flags an error.
   always_comb begin
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      par_d      = par_q;
      err_d      = err_q;
      valid_d    = 1'b0;
      state_d    = state_q;
      shiftSreg  = sreg_q;
      shiftCnt   = cnt_q;
      shiftState = state_q;

      if (clkRise) begin
         shiftSreg = {sreg_q[FRAME_BITS-2:0], soutLevel};
         shiftCnt  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
         case (state_q)
            IDLE:     shiftState = (shiftCnt >= FRAME_CNT) ? FULL : SHIFTING;
            SHIFTING: shiftState = (shiftCnt >= FRAME_CNT) ? FULL : SHIFTING;
            default:  shiftState = FULL;
         endcase
      end

      if (!clrnLevel) begin
         sreg_d  = '0;
         cnt_d   = '0;
         state_d = IDLE;
         if (penRise) begin
            err_d = 1'b1;
         end
      end else if (penRise) begin
         sreg_d  = shiftSreg;
         cnt_d   = '0;
         state_d = IDLE;
         if (shiftState == FULL && shiftCnt == FRAME_CNT) begin
            par_d   = shiftSreg;
            valid_d = 1'b1;
            err_d   = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         sreg_d  = shiftSreg;
         cnt_d   = shiftCnt;
         state_d = shiftState;
      end
   end

`ifdef DAISY_OUT_EN
   logic daisy_q, daisy_d;

   // The bit falling off the top of the shift register is forwarded so a
   // second receiver can be chained behind this one.
   always_comb begin
      daisy_d = daisy_q;
      if (clkRise && clrnLevel) begin
         daisy_d = sreg_q[FRAME_BITS-1];
      end
   end

   // Daisy output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         daisy_q <= 1'b0;
      end else begin
         daisy_q <= daisy_d;
      end
   end

   assign daisy_out = daisy_q;
`endif

   assign par_out     = par_q;
   assign frame_valid = valid_q;
   assign frame_err   = err_q;
   assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_serial_disp_receiver.sv
// ============================================================================
// tb_serial_disp_receiver
// Self-checking bench for serial_disp_receiver with FRAME_BITS=16. Directed
// frames come from a vector table, random frames are checked against a
// bit-history model, and the multi-cycle corner cases are hand-written.
// Define DAISY_OUT_EN to also exercise the daisy_out output.
// ============================================================================
module tb_serial_disp_receiver;
   import serial_disp_pkg::*;

   localparam int FB   = LED_FRAME_BITS;
   localparam int SS   = DEF_SYNC_STAGES;
   localparam int CW   = 8;
   localparam int HOLD = SS + 3;
   localparam int LAT  = SS + 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, serClk, serSout, serPen, serClrn;
   logic [FB-1:0] parOut;
   logic          frameValid, frameErr;
   logic [CW-1:0] bitCnt;
`ifdef DAISY_OUT_EN
   logic          daisyOut;
`endif

   always #5 clk = ~clk;

   serial_disp_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .ser_clk(serClk),
      .ser_sout(serSout),
      .ser_pen(serPen),
      .ser_clrn(serClrn),
      .par_out(parOut),
      .frame_valid(frameValid),
      .frame_err(frameErr),
`ifdef DAISY_OUT_EN
      .bit_cnt(bitCnt),
      .daisy_out(daisyOut)
`else
      .bit_cnt(bitCnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: history of bits shifted since the last clear, a count
   // of shifts since the last commit/clear, and the last committed result.
   bit            hist[$];
   int            mCnt;
   logic [FB-1:0] mPar;
   bit            mErr;
   bit            mValid;

   typedef struct {
      int          preBits;
      logic [31:0] preData;
      int          nBits;
      logic [31:0] data;
      logic [15:0] expPar;
      bit          expErr;
      int          expPulses;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(string name, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic logic [FB-1:0] mSreg();
      logic [FB-1:0] r;
      r = '0;
      for (int i = 0; i < FB; i++) begin
         if (hist.size() > i) r[i] = hist[hist.size() - 1 - i];
      end
      return r;
   endfunction

   task automatic mShift(bit b);
      hist.push_back(b);
      if (hist.size() > FB) void'(hist.pop_front());
      if (mCnt < CMAX) mCnt++;
   endtask

   task automatic mClear();
      hist.delete();
      mCnt = 0;
   endtask

   task automatic mCommit();
      mValid = (mCnt == FB);
      if (mValid) mPar = mSreg();
      mErr = !mValid;
      mCnt = 0;
   endtask

   task automatic mReset();
      mClear();
      mPar = '0;
      mErr = 1'b0;
   endtask

   task automatic waitCycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic shiftBit(bit b);
      serSout = b;
      waitCycles(HOLD);
      serClk = 1'b1;
      waitCycles(HOLD);
      serClk = 1'b0;
      mShift(b);
   endtask

   task automatic shiftWord(int n, logic [63:0] d);
      for (int i = n - 1; i >= 0; i--) shiftBit(d[i]);
   endtask

   task automatic clearPulse(int n);
      serClrn = 1'b0;
      waitCycles(6);
      @(negedge clk);
      checkOutput("bit_cnt_during_clear", bitCnt, 0);
      waitCycles(n - 6);
      serClrn = 1'b1;
      waitCycles(HOLD);
      mClear();
   endtask

   // Raises ser_pen (optionally together with a ser_clk rise or a clear),
   // holds it while counting frame_valid pulses and the cycle of the first.
   task automatic applyStimulus(input bit alsoShift, input bit alsoClear,
                                output int pulses, output int latency);
      serPen = 1'b1;
      if (alsoShift) serClk = 1'b1;
      if (alsoClear) serClrn = 1'b0;
      pulses  = 0;
      latency = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (frameValid === 1'b1) begin
            pulses++;
            if (latency < 0) latency = c;
         end
      end
      serPen  = 1'b0;
      serClk  = 1'b0;
      serClrn = 1'b1;
      waitCycles(HOLD + 1);
      if (alsoShift) mShift(serSout);
      if (alsoClear) begin
         mClear();
         mCommit();
      end else begin
         mCommit();
      end
   endtask

   task automatic checkAgainstModel(string tag, int pulses, int latency);
      checkOutput({tag, "_pulses"}, pulses, mValid ? 1 : 0);
      if (mValid) checkOutput({tag, "_latency"}, latency, LAT);
      checkOutput({tag, "_par_out"}, parOut, mPar);
      checkOutput({tag, "_frame_err"}, frameErr, mErr);
      checkOutput({tag, "_bit_cnt"}, bitCnt, 0);
   endtask

   initial begin
      int          pulses, latency, len;
      logic [31:0] rdata;
      logic [31:0] daisyWord;

      vecs[0] = '{0, 32'h0,  16, 32'hA5C3,  16'hA5C3, 1'b0, 1};
      vecs[1] = '{0, 32'h0,  15, 32'h7FFF,  16'hA5C3, 1'b1, 0};
      vecs[2] = '{0, 32'h0,  16, 32'h1234,  16'h1234, 1'b0, 1};
      vecs[3] = '{8, 32'hAB, 16, 32'hFFFF,  16'hFFFF, 1'b0, 1};
      vecs[4] = '{0, 32'h0,  20, 32'hF0F0F, 16'hFFFF, 1'b1, 0};
      vecs[5] = '{0, 32'h0,  0,  32'h0,     16'hFFFF, 1'b1, 0};
      vecs[6] = '{0, 32'h0,  16, 32'h0000,  16'h0000, 1'b0, 1};

      rst = 1'b1; serClk = 1'b0; serSout = 1'b0; serPen = 1'b0; serClrn = 1'b1;
      mReset();
      waitCycles(3);
      @(negedge clk);
      checkOutput("reset_par_out", parOut, 0);
      checkOutput("reset_frame_valid", frameValid, 0);
      checkOutput("reset_frame_err", frameErr, 0);
      checkOutput("reset_bit_cnt", bitCnt, 0);
`ifdef DAISY_OUT_EN
      checkOutput("reset_daisy_out", daisyOut, 0);
`endif
      rst = 1'b0;
      waitCycles(HOLD + 2);

      // Directed frames from the vector table.
      for (int v = 0; v < 7; v++) begin
         if (vecs[v].preBits > 0) begin
            shiftWord(vecs[v].preBits, {32'h0, vecs[v].preData});
            clearPulse(10);
         end
         shiftWord(vecs[v].nBits, {32'h0, vecs[v].data});
         checkOutput($sformatf("vec%0d_bit_cnt_pre", v), bitCnt, vecs[v].nBits);
         applyStimulus(1'b0, 1'b0, pulses, latency);
         checkOutput($sformatf("vec%0d_pulses", v), pulses, vecs[v].expPulses);
         if (vecs[v].expPulses == 1)
            checkOutput($sformatf("vec%0d_latency", v), latency, LAT);
         checkOutput($sformatf("vec%0d_par_out", v), parOut, vecs[v].expPar);
         checkOutput($sformatf("vec%0d_frame_err", v), frameErr, vecs[v].expErr);
         checkOutput($sformatf("vec%0d_bit_cnt_post", v), bitCnt, 0);
      end

      // Random frames against the model.
      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(0, 4) == 0) begin
            shiftWord($urandom_range(1, 6), {32'h0, $urandom});
            clearPulse(8);
         end
         len   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : FB;
         rdata = $urandom;
         shiftWord(len, {32'h0, rdata});
         checkOutput($sformatf("rand%0d_bit_cnt", r), bitCnt, mCnt);
         applyStimulus(1'b0, 1'b0, pulses, latency);
         checkAgainstModel($sformatf("rand%0d", r), pulses, latency);
      end

      // Saturation of the bit counter.
      for (int i = 0; i < 300; i++) shiftBit(1'($urandom_range(0, 1)));
      checkOutput("sat_bit_cnt", bitCnt, CMAX);
      applyStimulus(1'b0, 1'b0, pulses, latency);
      checkOutput("sat_frame_err", frameErr, 1);
      checkAgainstModel("sat", pulses, latency);

      // Shift rise and commit rise on the same edge: the 16th bit is included.
      shiftWord(15, 64'(16'hBEAD >> 1));
      serSout = 1'b1;
      waitCycles(HOLD);
      applyStimulus(1'b1, 1'b0, pulses, latency);
      checkOutput("same_edge_par_out", parOut, 16'hBEAD);
      checkOutput("same_edge_pulses", pulses, 1);
      checkOutput("same_edge_latency", latency, LAT);
      checkOutput("same_edge_frame_err", frameErr, 0);

      // Commit and clear together: clear wins, commit counts as empty.
      shiftWord(16, 64'h5A5A);
      applyStimulus(1'b0, 1'b1, pulses, latency);
      checkOutput("clr_commit_pulses", pulses, 0);
      checkOutput("clr_commit_frame_err", frameErr, 1);
      checkOutput("clr_commit_par_out", parOut, 16'hBEAD);
      checkAgainstModel("clr_commit", pulses, latency);

      // Reset mid-frame.
      shiftWord(5, 64'h15);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_par_out", parOut, 0);
      checkOutput("midrst_frame_err", frameErr, 0);
      checkOutput("midrst_frame_valid", frameValid, 0);
      checkOutput("midrst_bit_cnt", bitCnt, 0);
      rst = 1'b0;
      mReset();
      waitCycles(HOLD + 4);
      checkOutput("postrst_bit_cnt", bitCnt, 0);

`ifdef DAISY_OUT_EN
      // Daisy output replays the first frame while the second shifts in.
      daisyWord = 32'hBEEF_0001;
      for (int i = 31; i >= 0; i--) begin
         shiftBit(daisyWord[i]);
         if (i < 16) checkOutput($sformatf("daisy_bit%0d", i), daisyOut, daisyWord[i + 16]);
      end
      applyStimulus(1'b0, 1'b0, pulses, latency);
      checkAgainstModel("daisy", pulses, latency);
`else
      daisyWord = 32'h0;
`endif

      // Recovery after reset.
      shiftWord(16, 64'hC3C3);
      applyStimulus(1'b0, 1'b0, pulses, latency);
      checkOutput("recover_par_out", parOut, 16'hC3C3);
      checkAgainstModel("recover", pulses, latency);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
